// File: rtl/hazard_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_unit_pkg
// Shared definitions for the pipeline hazard controller:
//   - forwarding select encodings driven onto forwardAE / forwardBE
//   - the per-stage record {dest, reg_write, load} and its field widths
//   - the forward-select function used for both EX operands
// -----------------------------------------------------------------------------
package hazard_unit_pkg;

   // Width of the destination-register field in a stage record.
   localparam int unsigned REC_DEST_W = 5;

   // Forwarding source select for an EX operand.
   typedef enum logic [1:0] {
      FWD_RF   = 2'd0,   // register file
      FWD_LATE = 2'd1,   // one stage past write-back
      FWD_WB   = 2'd2,   // write-back stage
      FWD_MEM  = 2'd3    // memory stage (ALU result only)
   } fwd_sel_t;

   // One in-flight instruction as seen by the hazard logic.
   typedef struct packed {
      logic [REC_DEST_W-1:0] dest;
      logic                  reg_write;
      logic                  load;
   } stage_rec_t;

   localparam int unsigned REC_W = $bits(stage_rec_t);

   // A record can supply a value for addr only if it writes a non-zero
   // register equal to addr; register 0 is hard-wired and never forwarded.
   function automatic logic rec_match(input stage_rec_t            rec,
                                      input logic [REC_DEST_W-1:0] addr);
      return rec.reg_write && (rec.dest != '0) && (rec.dest == addr);
   endfunction

   // Youngest matching producer wins. A load sitting in MEM has no data yet,
   // so it is never a MEM-forward source; the stall logic keeps a dependent
   // instruction out of EX in that situation.
   function automatic fwd_sel_t fwd_select(input logic [REC_DEST_W-1:0] addr,
                                           input logic                  uses,
                                           input stage_rec_t            mem,
                                           input stage_rec_t            wb,
                                           input stage_rec_t            late);
      fwd_sel_t sel;
      sel = FWD_RF;
      if (uses) begin
         if (rec_match(mem, addr) && !mem.load) begin
            sel = FWD_MEM;
         end else if (rec_match(wb, addr)) begin
            sel = FWD_WB;
         end else if (rec_match(late, addr)) begin
            sel = FWD_LATE;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_stage_reg.sv
// -----------------------------------------------------------------------------
// hazard_stage_reg
// One pipeline-stage record {dest, reg_write, load} for the hazard unit.
// Ports:
//   clk     in   rising-edge clock
//   clear   in   synchronous clear (all fields to zero)
//   bubble  in   load an all-zero record instead of d on this edge
//   d       in   record from the previous stage
//   q       out  registered record
// -----------------------------------------------------------------------------
module hazard_stage_reg
   import hazard_unit_pkg::*;
(
   input  logic       clk,
   input  logic       clear,
   input  logic       bubble,
   input  stage_rec_t d,
   output stage_rec_t q
);

   always_ff @(posedge clk) begin
      if (clear || bubble) begin
         q <= '0;
      end else begin
         q <= d;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard controller for the five-stage CPU. Tracks the destination
// and write/load flags of every in-flight instruction from EX through one
// stage past write-back, and from those drives EX operand forwarding, the
// load-use stall (ID/EX enable, PC + IF/ID hold, EX bubble) and a saturating
// stall counter.
// Parameters:
//   REG_ADDR_W   register-address width (must match the package record width)
//   CNT_W        stall-counter width
// Ports:
//   clk           in   rising-edge clock
//   reset         in   synchronous active-high reset, clears all state
//   rs_d, rt_d    in   decode-stage source addresses
//   uses_rs_d     in   decode instruction reads rs
//   uses_rt_d     in   decode instruction reads rt
//   dest_d        in   decode-stage destination address
//   reg_write_d   in   decode instruction writes the register file
//   mem_to_reg_d  in   decode instruction is a load
//   forwardAE     out  EX operand-A source select
//   forwardBE     out  EX operand-B source select
//   load_stall    out  ID/EX enable: 1 = advance, 0 = hold
//   fetch_hold    out  hold PC and IF/ID
//   ex_bubble     out  zero EX control entering EX
//   stall_count   out  load-use stall cycles since reset, saturating
// -----------------------------------------------------------------------------
module hazard_unit
   import hazard_unit_pkg::*;
#(
   parameter int unsigned REG_ADDR_W = REC_DEST_W,
   parameter int unsigned CNT_W      = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [REG_ADDR_W-1:0] rs_d,
   input  logic [REG_ADDR_W-1:0] rt_d,
   input  logic                  uses_rs_d,
   input  logic                  uses_rt_d,
   input  logic [REG_ADDR_W-1:0] dest_d,
   input  logic                  reg_write_d,
   input  logic                  mem_to_reg_d,
   output logic [1:0]            forwardAE,
   output logic [1:0]            forwardBE,
   output logic                  load_stall,
   output logic                  fetch_hold,
   output logic                  ex_bubble,
   output logic [CNT_W-1:0]      stall_count
);

   stage_rec_t id_rec;
   stage_rec_t ex_rec;
   stage_rec_t mem_rec;
   stage_rec_t wb_rec;
   stage_rec_t late_rec;

   logic [REG_ADDR_W-1:0] rs_e;
   logic [REG_ADDR_W-1:0] rt_e;
   logic                  uses_rs_e;
   logic                  uses_rt_e;

   logic                  stall;
   fwd_sel_t              fwd_a;
   fwd_sel_t              fwd_b;

   assign id_rec = '{dest: dest_d, reg_write: reg_write_d, load: mem_to_reg_d};

   // ---------------------------------------------------------------- records
   // EX takes a bubble while the consumer is held in ID; the later stages
   // always advance so the load moves on and resolves the hazard.
   hazard_stage_reg u_ex (
      .clk    (clk),
      .clear  (reset),
      .bubble (stall),
      .d      (id_rec),
      .q      (ex_rec)
   );

   hazard_stage_reg u_mem (
      .clk    (clk),
      .clear  (reset),
      .bubble (1'b0),
      .d      (ex_rec),
      .q      (mem_rec)
   );

   hazard_stage_reg u_wb (
      .clk    (clk),
      .clear  (reset),
      .bubble (1'b0),
      .d      (mem_rec),
      .q      (wb_rec)
   );

   hazard_stage_reg u_late (
      .clk    (clk),
      .clear  (reset),
      .bubble (1'b0),
      .d      (wb_rec),
      .q      (late_rec)
   );

   // EX-only source operand fields, bubbled together with the EX record.
   always_ff @(posedge clk) begin
      if (reset || stall) begin
         rs_e      <= '0;
         rt_e      <= '0;
         uses_rs_e <= 1'b0;
         uses_rt_e <= 1'b0;
      end else begin
         rs_e      <= rs_d;
         rt_e      <= rt_d;
         uses_rs_e <= uses_rs_d;
         uses_rt_e <= uses_rt_d;
      end
   end

   // ----------------------------------------------------------------- stall
   // Load in EX whose result the decode instruction needs next cycle.
   always_comb begin
      stall = 1'b0;
      if (ex_rec.load && ex_rec.reg_write && (ex_rec.dest != '0)) begin
         stall = (uses_rs_d && (ex_rec.dest == rs_d)) ||
                 (uses_rt_d && (ex_rec.dest == rt_d));
      end
   end

   assign load_stall = !stall;
   assign fetch_hold = stall;
   assign ex_bubble  = stall;

   // ------------------------------------------------------------ forwarding
   assign fwd_a     = fwd_select(rs_e, uses_rs_e, mem_rec, wb_rec, late_rec);
   assign fwd_b     = fwd_select(rt_e, uses_rt_e, mem_rec, wb_rec, late_rec);
   assign forwardAE = fwd_a;
   assign forwardBE = fwd_b;

   // --------------------------------------------------------- stall counter
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_count <= '0;
      end else if (stall && (stall_count != '1)) begin
         stall_count <= stall_count + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
// Table-driven bench for hazard_unit. Each table row is one decode cycle:
// the ID-stage inputs plus the outputs expected in that cycle. A second
// instance with a 2-bit counter shares the stimulus to exercise saturation.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

   logic       clk;
   logic       reset;
   logic [4:0] rs_d;
   logic [4:0] rt_d;
   logic       uses_rs_d;
   logic       uses_rt_d;
   logic [4:0] dest_d;
   logic       reg_write_d;
   logic       mem_to_reg_d;

   logic [1:0]  forwardAE;
   logic [1:0]  forwardBE;
   logic        load_stall;
   logic        fetch_hold;
   logic        ex_bubble;
   logic [31:0] stall_count;

   logic [1:0]  s_forwardAE;
   logic [1:0]  s_forwardBE;
   logic        s_load_stall;
   logic        s_fetch_hold;
   logic        s_ex_bubble;
   logic [1:0]  s_stall_count;

   int unsigned checks = 0;
   int unsigned errors = 0;

   hazard_unit #(.REG_ADDR_W(5), .CNT_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .rs_d         (rs_d),
      .rt_d         (rt_d),
      .uses_rs_d    (uses_rs_d),
      .uses_rt_d    (uses_rt_d),
      .dest_d       (dest_d),
      .reg_write_d  (reg_write_d),
      .mem_to_reg_d (mem_to_reg_d),
      .forwardAE    (forwardAE),
      .forwardBE    (forwardBE),
      .load_stall   (load_stall),
      .fetch_hold   (fetch_hold),
      .ex_bubble    (ex_bubble),
      .stall_count  (stall_count)
   );

   hazard_unit #(.REG_ADDR_W(5), .CNT_W(2)) dut_small (
      .clk          (clk),
      .reset        (reset),
      .rs_d         (rs_d),
      .rt_d         (rt_d),
      .uses_rs_d    (uses_rs_d),
      .uses_rt_d    (uses_rt_d),
      .dest_d       (dest_d),
      .reg_write_d  (reg_write_d),
      .mem_to_reg_d (mem_to_reg_d),
      .forwardAE    (s_forwardAE),
      .forwardBE    (s_forwardBE),
      .load_stall   (s_load_stall),
      .fetch_hold   (s_fetch_hold),
      .ex_bubble    (s_ex_bubble),
      .stall_count  (s_stall_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic        urs;
      logic        urt;
      logic [4:0]  dest;
      logic        rw;
      logic        ld;
      logic [1:0]  fa;
      logic [1:0]  fb;
      logic        ls;
      int unsigned cnt;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input logic rst, input int rs, input int rt,
                              input logic urs, input logic urt, input int dest,
                              input logic rw, input logic ld,
                              input int fa, input int fb, input logic ls,
                              input int unsigned cnt);
      vec_t r;
      r.rst = rst;      r.rs = rs[4:0];     r.rt = rt[4:0];
      r.urs = urs;      r.urt = urt;        r.dest = dest[4:0];
      r.rw = rw;        r.ld = ld;
      r.fa = fa[1:0];   r.fb = fb[1:0];     r.ls = ls;
      r.cnt = cnt;
      return r;
   endfunction

   // Decode slot holding a bubble/NOP.
   function automatic vec_t nop(input int fa, input int fb, input int unsigned cnt);
      return v(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, fa, fb, 1'b1, cnt);
   endfunction

   task automatic chk(input string nm, input int row,
                      input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0h expected %0h", nm, row, act, exp);
      end
   endtask

   task automatic check_outputs(input int row, input logic [1:0] fa, input logic [1:0] fb,
                                input logic ls, input int unsigned cnt);
      int unsigned cnt_small;
      cnt_small = (cnt > 3) ? 3 : cnt;
      chk("forwardAE",   row, 32'(forwardAE),  32'(fa));
      chk("forwardBE",   row, 32'(forwardBE),  32'(fb));
      chk("load_stall",  row, 32'(load_stall), 32'(ls));
      chk("fetch_hold",  row, 32'(fetch_hold), 32'(!ls));
      chk("ex_bubble",   row, 32'(ex_bubble),  32'(!ls));
      chk("stall_count", row, stall_count,     cnt);
      chk("small_count", row, 32'(s_stall_count), cnt_small);
      // A load in MEM must never be the MEM-forward source.
      checks++;
      if (dut.mem_rec.load && ((forwardAE == 2'd3) || (forwardBE == 2'd3))) begin
         errors++;
         $display("FAIL mem_load_fwd row %0d: got fa=%0d fb=%0d expected no select 3",
                  row, forwardAE, forwardBE);
      end
   endtask

   initial begin
      // add $3,$1,$2 ; sub $4,$3,$5
      vecs.push_back(v(0, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 0));
      vecs.push_back(v(0, 3, 5, 1, 1, 4, 1, 0, 0, 0, 1, 0));
      vecs.push_back(nop(3, 0, 0));
      repeat (3) vecs.push_back(nop(0, 0, 0));
      // lw $3,0($1) ; add $4,$3,$3  (one stall, then WB forward)
      vecs.push_back(v(0, 1, 3, 1, 0, 3, 1, 1, 0, 0, 1, 0));
      vecs.push_back(v(0, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 0));
      vecs.push_back(v(0, 3, 3, 1, 1, 4, 1, 0, 0, 0, 1, 1));
      vecs.push_back(nop(2, 2, 1));
      repeat (3) vecs.push_back(nop(0, 0, 1));
      // $7 producer, two unrelated, reader -> LATE forward
      vecs.push_back(v(0, 1, 2, 1, 1, 7, 1, 0, 0, 0, 1, 1));
      vecs.push_back(v(0, 1, 2, 1, 1, 8, 1, 0, 0, 0, 1, 1));
      vecs.push_back(v(0, 1, 2, 1, 1, 9, 1, 0, 0, 0, 1, 1));
      vecs.push_back(v(0, 7, 1, 1, 1, 10, 1, 0, 0, 0, 1, 1));
      vecs.push_back(nop(1, 0, 1));
      // $7 producer, three unrelated, reader -> register file
      vecs.push_back(v(0, 1, 2, 1, 1, 7, 1, 0, 0, 0, 1, 1));
      vecs.push_back(v(0, 1, 2, 1, 1, 8, 1, 0, 0, 0, 1, 1));
      vecs.push_back(v(0, 1, 2, 1, 1, 9, 1, 0, 0, 0, 1, 1));
      vecs.push_back(v(0, 1, 2, 1, 1, 11, 1, 0, 0, 0, 1, 1));
      vecs.push_back(v(0, 7, 1, 1, 1, 10, 1, 0, 0, 0, 1, 1));
      vecs.push_back(nop(0, 0, 1));
      // add $3 ; add $3 ; sub $4,$3,$3 -> youngest (MEM) wins
      vecs.push_back(v(0, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 1));
      vecs.push_back(v(0, 1, 2, 1, 1, 3, 1, 0, 0, 0, 1, 1));
      vecs.push_back(v(0, 3, 3, 1, 1, 4, 1, 0, 0, 0, 1, 1));
      vecs.push_back(nop(3, 3, 1));
      // writes to $0, load to $0, $0 reader -> nothing
      vecs.push_back(v(0, 1, 2, 1, 1, 0, 1, 0, 0, 0, 1, 1));
      vecs.push_back(v(0, 1, 0, 1, 0, 0, 1, 1, 0, 0, 1, 1));
      vecs.push_back(v(0, 0, 0, 1, 1, 5, 1, 0, 0, 0, 1, 1));
      vecs.push_back(nop(0, 0, 1));
      // lw $6 ; immediate op with rt=$6 but rt not read -> no stall
      vecs.push_back(v(0, 1, 6, 1, 0, 6, 1, 1, 0, 0, 1, 1));
      vecs.push_back(v(0, 2, 6, 1, 0, 6, 1, 0, 0, 0, 1, 1));
      vecs.push_back(nop(0, 0, 1));
      // lw $3 ; lw $5,0($3) ; add $6,$5,$5 -> two independent stalls
      vecs.push_back(v(0, 1, 3, 1, 0, 3, 1, 1, 0, 0, 1, 1));
      vecs.push_back(v(0, 3, 5, 1, 0, 5, 1, 1, 0, 0, 0, 1));
      vecs.push_back(v(0, 3, 5, 1, 0, 5, 1, 1, 0, 0, 1, 2));
      vecs.push_back(v(0, 5, 5, 1, 1, 6, 1, 0, 2, 0, 0, 2));
      vecs.push_back(v(0, 5, 5, 1, 1, 6, 1, 0, 0, 0, 1, 3));
      vecs.push_back(nop(2, 2, 3));
      // fourth stall: 2-bit counter saturates at 3
      vecs.push_back(v(0, 1, 3, 1, 0, 3, 1, 1, 0, 0, 1, 3));
      vecs.push_back(v(0, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 3));
      vecs.push_back(v(0, 3, 3, 1, 1, 4, 1, 0, 0, 0, 1, 4));
      vecs.push_back(nop(2, 2, 4));
      // reset asserted during the stall cycle
      vecs.push_back(v(0, 1, 3, 1, 0, 3, 1, 1, 0, 0, 1, 4));
      vecs.push_back(v(1, 3, 3, 1, 1, 4, 1, 0, 0, 0, 0, 4));
      vecs.push_back(v(0, 3, 3, 1, 1, 4, 1, 0, 0, 0, 1, 0));
      vecs.push_back(nop(0, 0, 0));

      // Reset sequence and reset-state check.
      reset = 1'b1;
      rs_d = '0; rt_d = '0; uses_rs_d = 1'b0; uses_rt_d = 1'b0;
      dest_d = '0; reg_write_d = 1'b0; mem_to_reg_d = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      check_outputs(-1, 2'd0, 2'd0, 1'b1, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         reset        = vecs[i].rst;
         rs_d         = vecs[i].rs;
         rt_d         = vecs[i].rt;
         uses_rs_d    = vecs[i].urs;
         uses_rt_d    = vecs[i].urt;
         dest_d       = vecs[i].dest;
         reg_write_d  = vecs[i].rw;
         mem_to_reg_d = vecs[i].ld;
         @(negedge clk);
         check_outputs(i, vecs[i].fa, vecs[i].fb, vecs[i].ls, vecs[i].cnt);
         @(posedge clk);
         #1;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
